// File: rtl/sram_1rw_host_ctrl.sv
// Host-side sequencer for a single-port 1RW OpenRAM macro: one request at a time,
// registered strobes, read capture after RD_WAIT cycles with OEb low.
module sram_1rw_host_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_WAIT    = 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  output logic                  sram_data_oe,
  input  logic [DATA_WIDTH-1:0] sram_data_i
);

  typedef enum logic [1:0] {IDLE, WR, RD, RDWAIT} state_t;

  typedef struct packed {
    logic                  csb;
    logic                  web;
    logic                  oeb;
    logic                  data_oe;
    logic                  ready;
  } strobe_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept, capture;
  strobe_t    strb_d;

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_we ? WR : RD;
      WR:      state_d = IDLE;
      RD: begin
        state_d = RDWAIT;
        cnt_d   = 4'(RD_WAIT - 1);
      end
      RDWAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every pin comes straight off a flop.
  always_comb begin
    strb_d         = '{csb: 1'b1, web: 1'b1, oeb: 1'b1, data_oe: 1'b0, ready: 1'b0};
    case (state_d)
      IDLE:    strb_d.ready = 1'b1;
      WR: begin
        strb_d.csb     = 1'b0;
        strb_d.web     = 1'b0;
        strb_d.data_oe = 1'b1;
      end
      RD:      strb_d.csb = 1'b0;
      RDWAIT: begin
        strb_d.csb = 1'b0;
        strb_d.oeb = 1'b0;
      end
      default: strb_d.ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready    <= 1'b0;
      sram_csb     <= 1'b1;
      sram_web     <= 1'b1;
      sram_oeb     <= 1'b1;
      sram_data_oe <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      sram_addr    <= '0;
      sram_data_o  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready    <= strb_d.ready;
      sram_csb     <= strb_d.csb;
      sram_web     <= strb_d.web;
      sram_oeb     <= strb_d.oeb;
      sram_data_oe <= strb_d.data_oe;
      rsp_valid    <= capture;
      if (capture) rsp_rdata <= sram_data_i;
      if (accept) begin
        sram_addr   <= req_addr;
        sram_data_o <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_1rw_host_ctrl.sv
// Directed bench for sram_1rw_host_ctrl with a behavioural 1RW macro model,
// default RD_WAIT=1 instance plus an RD_WAIT=3 instance.
module tb_sram_1rw_host_ctrl;

  logic       clk = 1'b0;
  logic       rstb;
  logic       req_valid, req_we, req_ready, rsp_valid;
  logic [7:0] req_addr, req_wdata, rsp_rdata;
  logic [7:0] sram_addr, sram_data_o, sram_data_i;
  logic       sram_csb, sram_web, sram_oeb, sram_data_oe;

  logic       rv3, rwe3, rdy3, rsp_v3;
  logic [7:0] raddr3, rwd3, rsp_d3;
  logic [7:0] addr3, do3, di3;
  logic       csb3, web3, oeb3, doe3;

  int checks = 0;
  int errors = 0;
  int mon_err = 0;
  int mon_err3 = 0;
  logic prev_oeb = 1'b1;
  logic prev_oeb3 = 1'b1;

  always #5 clk = ~clk;

  sram_1rw_host_ctrl dut (
    .clk(clk), .rstb(rstb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i)
  );

  sram_1rw_host_ctrl #(.RD_WAIT(3)) dut3 (
    .clk(clk), .rstb(rstb),
    .req_valid(rv3), .req_ready(rdy3), .req_we(rwe3),
    .req_addr(raddr3), .req_wdata(rwd3),
    .rsp_valid(rsp_v3), .rsp_rdata(rsp_d3),
    .sram_addr(addr3), .sram_csb(csb3), .sram_web(web3), .sram_oeb(oeb3),
    .sram_data_o(do3), .sram_data_oe(doe3), .sram_data_i(di3)
  );

  // Macro models: synchronous read/write on the shared clock, DATA driven only with OEb low.
  logic [7:0] mem0 [256];
  logic [7:0] mem3 [256];
  logic [7:0] dout0, dout3;
  always @(posedge clk) begin
    if (!sram_csb && !sram_web) mem0[sram_addr] <= sram_data_o;
    if (!sram_csb && sram_web)  dout0 <= mem0[sram_addr];
    if (!csb3 && !web3)         mem3[addr3] <= do3;
    if (!csb3 && web3)          dout3 <= mem3[addr3];
  end
  assign sram_data_i = sram_oeb ? 8'h00 : dout0;
  assign di3         = oeb3 ? 8'h00 : dout3;

  // Bus-contention / busy-ready monitors, tallied and checked at the end.
  always @(negedge clk) begin
    if (rstb) begin
      mon_err  <= mon_err + int'(sram_data_oe && !sram_oeb) + int'(req_ready && !sram_csb)
                  + int'(!sram_csb && !sram_web && !prev_oeb);
      mon_err3 <= mon_err3 + int'(doe3 && !oeb3) + int'(rdy3 && !csb3)
                  + int'(!csb3 && !web3 && !prev_oeb3);
    end
    prev_oeb  <= sram_oeb;
    prev_oeb3 <= oeb3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", req_ready, 1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_we = 1'b0;
    chk("wr_csb", sram_csb, 0);
    chk("wr_web", sram_web, 0);
    chk("wr_oeb", sram_oeb, 1);
    chk("wr_oe", sram_data_oe, 1);
    chk("wr_addr", sram_addr, a);
    chk("wr_data", sram_data_o, d);
    chk("wr_ready", req_ready, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
    int n = 0;
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0;
    chk("rd_csb", sram_csb, 0);
    chk("rd_web", sram_web, 1);
    chk("rd_oeb", sram_oeb, 1);
    chk("rd_oe", sram_data_oe, 0);
    chk("rd_addr", sram_addr, a);
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("rd_latency", n, 2);
    chk("rd_data", rsp_rdata, exp);
    step();
    chk("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    int n, oeb_low, last, pulses;
    logic [7:0] av;
    rstb = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rv3 = 1'b0; rwe3 = 1'b0; raddr3 = '0; rwd3 = '0;

    // Reset asserted mid-cycle takes effect without a clock edge.
    #2 rstb = 1'b0;
    #1;
    chk("rst_csb", sram_csb, 1);
    chk("rst_web", sram_web, 1);
    chk("rst_oeb", sram_oeb, 1);
    chk("rst_oe", sram_data_oe, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_data_o, 0);
    chk("rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #3 rstb = 1'b1;
    #1 chk("ready_before_edge", req_ready, 0);
    step();
    chk("ready_after_edge", req_ready, 1);
    chk("ready3_after_edge", rdy3, 1);

    do_write(8'h3A, 8'hC5);
    do_read(8'h3A, 8'hC5);

    // RD_WAIT=3 instance: store 0x5A at 0xFF, then read it back.
    rv3 = 1'b1; rwe3 = 1'b1; raddr3 = 8'hFF; rwd3 = 8'h5A;
    step();
    rv3 = 1'b0; rwe3 = 1'b0;
    chk("w3_web", web3, 0);
    step();
    chk("w3_ready", rdy3, 1);
    rv3 = 1'b1; raddr3 = 8'hFF;
    step();
    rv3 = 1'b0;
    n = 0; oeb_low = 0;
    while (!rsp_v3 && n < 20) begin
      step();
      n++;
      if (!oeb3) oeb_low++;
    end
    chk("rd3_latency", n, 4);
    chk("rd3_oeb_cycles", oeb_low, 3);
    chk("rd3_data", rsp_d3, 8'h5A);
    step();
    chk("rd3_pulse", rsp_v3, 0);

    // Back-to-back writes of ~addr interleaved with reads.
    for (int a = 0; a < 256; a += 2) begin
      av = a[7:0];
      do_write(av, ~av);
      do_write(av + 8'd1, ~(av + 8'd1));
      do_read(av, ~av);
      do_read(av + 8'd1, ~(av + 8'd1));
    end

    // Reset during RDWAIT drops the read.
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h3A;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_oeb_low", sram_oeb, 0);
    #2 rstb = 1'b0;
    #1;
    chk("mid_rst_csb", sram_csb, 1);
    chk("mid_rst_oeb", sram_oeb, 1);
    chk("mid_rst_rspv", rsp_valid, 0);
    repeat (2) step();
    chk("mid_no_rsp", rsp_valid, 0);
    #2 rstb = 1'b1;
    step();
    chk("mid_ready", req_ready, 1);
    do_read(8'h3A, 8'hC5);

    // Held read request; garbage on the request lines while busy must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    last = -1; pulses = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (rsp_valid) begin
        chk("held_data", rsp_rdata, 8'hEF);
        if (last >= 0) chk("held_interval", e - last, 3);
        last = e;
        pulses++;
      end
      if (req_ready) begin
        req_we = 1'b0; req_addr = 8'h10;
      end else begin
        req_we = 1'b1; req_addr = 8'h99; req_wdata = 8'h00;
      end
    end
    req_valid = 1'b0; req_we = 1'b0;
    chk("held_pulses", pulses, 4);
    do_read(8'h99, 8'h66);
    do_read(8'h10, 8'hEF);

    step();
    chk("monitor", mon_err, 0);
    chk("monitor3", mon_err3, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1rw_host_ctrl.md
# sram_1rw_host_ctrl

Host-side controller driving the single-port OpenRAM SRAM macro (1RW, DATA/ADDR/CSb/WEb/OEb/clk pin set). It accepts one read or write request at a time over a valid/ready handshake. It sequences the SRAM control strobes and captures read data after a programmable wait. Read data returns on a one-cycle response strobe. It sits between the system bus logic and the macro; the shared DATA tristate is resolved at the top level from the split data signals below.

## Interface
- DATA_WIDTH, 8, SRAM word width
- ADDR_WIDTH, 8, SRAM address width (256 words)
- RD_WAIT, 1, cycles the bus is held with OEb low before read capture; legal range 1..15

Ports:
- clk  in  1  clock; SRAM shares this clock
- rstb  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse; rsp_rdata valid
- rsp_rdata  out  DATA_WIDTH  read data, held until next capture
- sram_addr  out  ADDR_WIDTH  to macro ADDR
- sram_csb  out  1  to macro CSb
- sram_web  out  1  to macro WEb
- sram_oeb  out  1  to macro OEb
- sram_data_o  out  DATA_WIDTH  write data to DATA pad
- sram_data_oe  out  1  drive enable for DATA pad
- sram_data_i  in  DATA_WIDTH  DATA pad input

## Operation
- All outputs are registered; each is a function of the state register and the latched request.
- States: IDLE, WR, RD, RDWAIT. Wait counter width is 4 bits.
- IDLE: req_ready=1; csb=1, web=1, oeb=1, data_oe=0. On req_valid at the clock edge:
  - latch addr and wdata;
  - req_we=1 goes to WR; req_we=0 goes to RD.
- WR (1 cycle): csb=0, web=0, oeb=1, data_oe=1, sram_addr/sram_data_o = latched values. The macro writes at the closing edge. Next state is IDLE.
- RD (1 cycle): csb=0, web=1, oeb=1, data_oe=0. The macro samples ADDR at the closing edge. Next state is RDWAIT; counter loads RD_WAIT-1.
- RDWAIT (RD_WAIT cycles): csb=0, web=1, oeb=0, data_oe=0, address held. Repeated macro reads of the same address are harmless.
  - counter != 0: decrement.
  - counter == 0: capture sram_data_i into rsp_rdata, set rsp_valid for exactly one cycle, go to IDLE.
- Bus contention is excluded by construction. Any write is preceded by at least one IDLE cycle with oeb=1, and data_oe is never 1 while oeb=0. The bench checks this as an assertion.
- No response is produced for writes.
- req_* inputs are ignored outside IDLE.
- rstb low asynchronously forces:
  - state IDLE, csb=1, web=1, oeb=1, data_oe=0;
  - rsp_valid=0, rsp_rdata=0, sram_addr=0, sram_data_o=0;
  - req_ready=1 once the first edge after rstb deasserts has occurred (0 while in reset).
- An in-flight request interrupted by reset is dropped and produces no rsp_valid.

## Timing
- Write: accepted at edge E0; WR occupies cycle E0..E1; macro writes at E1; req_ready high again after E1. Throughput is one write per 2 cycles.
- Read: accepted at E0; RD cycle E0..E1; RDWAIT cycles E1..E(1+RD_WAIT); capture at E(1+RD_WAIT); rsp_valid high for the cycle after it. Default RD_WAIT=1 gives capture at E2, so request-to-response is 2 edges and throughput is one read per RD_WAIT+2 cycles.
- Clock period times RD_WAIT must exceed the macro read delay plus pad delay (macro model: 3 time units).
- Read after write to the same address returns the new data, because the write completes at E1 before the read can be accepted.

## Test plan
- Reset values: assert rstb mid-clock -> all outputs reach reset values immediately; req_ready=1 after the first edge following release.
- Write then read: write addr 0x3A data 0xC5, then read 0x3A -> rsp_valid one cycle, rsp_rdata=0xC5, 2 edges after read accept.
- RD_WAIT=3 build: read addr 0xFF holding 0x5A -> oeb low for 3 cycles; rsp_valid 4 edges after accept; rsp_rdata=0x5A.
- Alternating traffic: write 0x00..0xFF with data=~addr, back-to-back, interleaved with reads -> every read returns ~addr; contention assertion never fires; req_ready low in every non-IDLE cycle.
- Reset mid-read: assert rstb during RDWAIT -> no rsp_valid; csb/oeb high immediately; next read of the same address returns the stored value.
- Held request: req_valid held high with req_we=0, addr=0x10 -> one read accepted per RD_WAIT+2 cycles; inputs ignored while busy.
